// File: rtl/list_reducer_pkg.sv
// Shared types for the cons-cell list reducer: word tags, reduction modes,
// error codes and the reducer state encoding.
package list_reducer_pkg;

    typedef enum logic [1:0] {
        TAG_NIL  = 2'd0,
        TAG_NUM  = 2'd1,
        TAG_CONS = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        MODE_FETCH  = 2'd0,
        MODE_LENGTH = 2'd1,
        MODE_SUM    = 2'd2,
        MODE_MAX    = 2'd3
    } reduce_mode_t;

    // Codes 0..3 come from the older fetch/eval datapath; 4 and 5 are list-walk faults.
    typedef enum logic [3:0] {
        STATE_ERROR = 4'd0,
        FETCH_ERROR = 4'd1,
        EVAL_ERROR  = 4'd2,
        APPLY_ERROR = 4'd3,
        TAG_ERROR   = 4'd4,
        STEP_ERROR  = 4'd5
    } error_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_PTR  = 3'd1,
        ST_WAIT_PTR = 3'd2,
        ST_REQ_CAR  = 3'd3,
        ST_WAIT_CAR = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERROR    = 3'd6
    } reducer_state_t;

endpackage

// File: rtl/list_accumulator.sv
// Combinational per-mode accumulator update for one car word, with the
// SUM carry-out and the "car must be a number" check.
module list_accumulator
    import list_reducer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic [1:0]                      mode,
    input  logic [DATA_WIDTH-TAG_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]           car,
    output logic [DATA_WIDTH-TAG_WIDTH-1:0] acc_next,
    output logic                            carry,
    output logic                            tag_ok
);

    localparam int PW = DATA_WIDTH - TAG_WIDTH;

    logic [TAG_WIDTH-1:0] car_tag;
    logic [PW-1:0]        car_payload;
    logic [PW:0]          sum_ext;
    logic                 car_is_num;

    assign car_tag     = car[DATA_WIDTH-1 -: TAG_WIDTH];
    assign car_payload = car[PW-1:0];
    assign car_is_num  = (car_tag == TAG_WIDTH'(TAG_NUM));
    assign sum_ext     = {1'b0, acc} + {1'b0, car_payload};

    // LENGTH counts any car; SUM and MAX only accept numeric cars.
    always_comb begin
        acc_next = acc;
        carry    = 1'b0;
        tag_ok   = 1'b1;
        case (reduce_mode_t'(mode))
            MODE_LENGTH: begin
                acc_next = acc + PW'(1);
            end
            MODE_SUM: begin
                tag_ok   = car_is_num;
                acc_next = sum_ext[PW-1:0];
                carry    = sum_ext[PW];
            end
            MODE_MAX: begin
                tag_ok = car_is_num;
                if (car_payload > acc) begin
                    acc_next = car_payload;
                end
            end
            default: begin
                acc_next = acc;
            end
        endcase
    end

endmodule

// File: rtl/list_reducer.sv
// Walks a cons-cell list from a root pointer and reduces it (fetch, length,
// sum, max) over a one-outstanding, variable-latency memory read handshake.
module list_reducer
    import list_reducer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int MAX_STEPS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] root_addr,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  error,
    output logic [3:0]            error_code,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int PW         = DATA_WIDTH - TAG_WIDTH;
    localparam int STEP_WIDTH = $clog2(MAX_STEPS + 1);

    reducer_state_t        state, state_d;
    reduce_mode_t          mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] ptr_addr, ptr_addr_d;
    logic [ADDR_WIDTH-1:0] cell_addr, cell_addr_d;
    logic [PW-1:0]         acc, acc_d, acc_upd;
    logic [STEP_WIDTH-1:0] step_cnt, step_cnt_d;
    logic [DATA_WIDTH-1:0] result_d;
    logic                  overflow_d;
    logic [3:0]            error_code_d;
    logic                  acc_carry;
    logic                  car_tag_ok;
    logic [TAG_WIDTH-1:0]  rd_tag;
    logic [PW-1:0]         rd_payload;

    assign rd_tag     = mem_rdata[DATA_WIDTH-1 -: TAG_WIDTH];
    assign rd_payload = mem_rdata[PW-1:0];

    list_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_accumulator (
        .mode     (mode_q),
        .acc      (acc),
        .car      (mem_rdata),
        .acc_next (acc_upd),
        .carry    (acc_carry),
        .tag_ok   (car_tag_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_FETCH;
            ptr_addr   <= '0;
            cell_addr  <= '0;
            acc        <= '0;
            step_cnt   <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            error_code <= 4'd0;
        end else begin
            mode_q     <= mode_d;
            ptr_addr   <= ptr_addr_d;
            cell_addr  <= cell_addr_d;
            acc        <= acc_d;
            step_cnt   <= step_cnt_d;
            result     <= result_d;
            overflow   <= overflow_d;
            error_code <= error_code_d;
        end
    end

    // mem_rvalid is only looked at in the two wait states, so stale responses are dropped.
    always_comb begin
        state_d      = state;
        mode_d       = mode_q;
        ptr_addr_d   = ptr_addr;
        cell_addr_d  = cell_addr;
        acc_d        = acc;
        step_cnt_d   = step_cnt;
        result_d     = result;
        overflow_d   = overflow;
        error_code_d = error_code;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;

        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                done  = (state == ST_DONE);
                error = (state == ST_ERROR);
                if (start) begin
                    state_d    = ST_REQ_PTR;
                    mode_d     = reduce_mode_t'(mode);
                    ptr_addr_d = root_addr;
                    acc_d      = '0;
                    step_cnt_d = '0;
                    result_d   = '0;
                    overflow_d = 1'b0;
                end
            end

            ST_REQ_PTR: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = ptr_addr;
                state_d  = ST_WAIT_PTR;
            end

            ST_WAIT_PTR: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    if (mode_q == MODE_FETCH) begin
                        result_d = mem_rdata;
                        state_d  = ST_DONE;
                    end else if (rd_tag == TAG_WIDTH'(TAG_NIL)) begin
                        result_d = DATA_WIDTH'(acc);
                        state_d  = ST_DONE;
                    end else if (rd_tag == TAG_WIDTH'(TAG_CONS)) begin
                        cell_addr_d = ADDR_WIDTH'(rd_payload);
                        state_d     = ST_REQ_CAR;
                    end else begin
                        error_code_d = TAG_ERROR;
                        state_d      = ST_ERROR;
                    end
                end
            end

            // The step guard trips before the request goes out, so a cyclic
            // list reads exactly MAX_STEPS cars.
            ST_REQ_CAR: begin
                busy = 1'b1;
                if (step_cnt == STEP_WIDTH'(MAX_STEPS)) begin
                    error_code_d = STEP_ERROR;
                    state_d      = ST_ERROR;
                end else begin
                    mem_req    = 1'b1;
                    mem_addr   = cell_addr;
                    step_cnt_d = step_cnt + STEP_WIDTH'(1);
                    state_d    = ST_WAIT_CAR;
                end
            end

            ST_WAIT_CAR: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    if (!car_tag_ok) begin
                        error_code_d = TAG_ERROR;
                        state_d      = ST_ERROR;
                    end else begin
                        acc_d      = acc_upd;
                        overflow_d = overflow | acc_carry;
                        ptr_addr_d = cell_addr + ADDR_WIDTH'(1);
                        state_d    = ST_REQ_PTR;
                    end
                end
            end

            default: begin
                error_code_d = STATE_ERROR;
                state_d      = ST_ERROR;
            end
        endcase
    end

endmodule

// File: tb/tb_list_reducer.sv
// Directed bench for list_reducer: a latency-programmable memory model plus a
// vector table of list walks and a few hand-written control sequences.
module tb_list_reducer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] root_addr;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;
    logic        error;
    logic [3:0]  error_code;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int req_count = 0;
    int car62_count = 0;
    int resp_delay = 0;
    int cycle_cnt = 0;
    logic [15:0] pend_addr = 16'h0000;
    logic [15:0] mem [0:65535];

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] root;
        int          lat;
        logic [15:0] exp_result;
        logic        exp_ovf;
        logic        exp_err;
        logic [3:0]  exp_code;
        int          exp_cycles;
        int          exp_reqs;
        int          exp_car62;
    } vec_t;

    vec_t vecs [15];

    list_reducer #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .TAG_WIDTH  (4),
        .MAX_STEPS  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .root_addr  (root_addr),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .error      (error),
        .error_code (error_code),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: a request seen in cycle c is answered with rvalid high across
    // the edge ending cycle c+mem_lat.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (resp_delay > 0) begin
                resp_delay--;
                if (resp_delay == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[pend_addr];
                end
            end
            if (mem_req) begin
                req_count++;
                if (mem_addr == 16'h0062) car62_count++;
                pend_addr  = mem_addr;
                resp_delay = mem_lat;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] r, input int lat);
        mem_lat = lat;
        @(negedge clk);
        start     = 1'b1;
        mode      = m;
        root_addr = r;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cycle_cnt = 1;
    endtask

    task automatic waitDone(input string tag);
        while (!(done || error) && cycle_cnt < 600) begin
            @(posedge clk);
            #1;
            cycle_cnt++;
        end
        checkOutput({tag, " finished"}, 32'(done | error), 32'd1);
    endtask

    initial begin
        int base_req;
        int base_car;
        int bad_cycles;
        logic [3:0] exp_code_track;
        string tag;

        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        root_addr = 16'h0000;
        exp_code_track = 4'd0;

        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[16'h0010] = 16'h1234;
        // {3,5,7}
        mem[16'h0018] = 16'h2020;
        mem[16'h0020] = 16'h1003; mem[16'h0021] = 16'h2022;
        mem[16'h0022] = 16'h1005; mem[16'h0023] = 16'h2024;
        mem[16'h0024] = 16'h1007; mem[16'h0025] = 16'h0000;
        // {0x7FF,0xFFF,0x001}
        mem[16'h0030] = 16'h2032;
        mem[16'h0032] = 16'h17FF; mem[16'h0033] = 16'h2034;
        mem[16'h0034] = 16'h1FFF; mem[16'h0035] = 16'h2036;
        mem[16'h0036] = 16'h1001; mem[16'h0037] = 16'h0000;
        // empty list at 0x40; {0xFFF,0x002}
        mem[16'h0048] = 16'h204A;
        mem[16'h004A] = 16'h1FFF; mem[16'h004B] = 16'h204C;
        mem[16'h004C] = 16'h1002; mem[16'h004D] = 16'h0000;
        // second car tagged CONS
        mem[16'h0050] = 16'h2052;
        mem[16'h0052] = 16'h1001; mem[16'h0053] = 16'h2054;
        mem[16'h0054] = 16'h2060; mem[16'h0055] = 16'h0000;
        // root word with illegal tag 3
        mem[16'h0058] = 16'h3000;
        // self-referencing cdr
        mem[16'h0060] = 16'h2062;
        mem[16'h0062] = 16'h1001; mem[16'h0063] = 16'h2062;

        //           mode   root      L  result    ovf   err   code  cyc rq car62
        vecs[0]  = '{2'd0, 16'h0010, 1, 16'h1234, 1'b0, 1'b0, 4'd0,  3,  1, 0};
        vecs[1]  = '{2'd2, 16'h0018, 3, 16'h000F, 1'b0, 1'b0, 4'd0, 29,  7, 0};
        vecs[2]  = '{2'd3, 16'h0030, 2, 16'h0FFF, 1'b0, 1'b0, 4'd0, 22,  7, 0};
        vecs[3]  = '{2'd1, 16'h0030, 1, 16'h0003, 1'b0, 1'b0, 4'd0, 15,  7, 0};
        vecs[4]  = '{2'd1, 16'h0040, 1, 16'h0000, 1'b0, 1'b0, 4'd0,  3,  1, 0};
        vecs[5]  = '{2'd2, 16'h0040, 2, 16'h0000, 1'b0, 1'b0, 4'd0,  4,  1, 0};
        vecs[6]  = '{2'd3, 16'h0040, 4, 16'h0000, 1'b0, 1'b0, 4'd0,  6,  1, 0};
        vecs[7]  = '{2'd2, 16'h0048, 1, 16'h0001, 1'b1, 1'b0, 4'd0, 11,  5, 0};
        vecs[8]  = '{2'd2, 16'h0050, 1, 16'h0000, 1'b0, 1'b1, 4'd4,  9,  4, 0};
        vecs[9]  = '{2'd1, 16'h0050, 1, 16'h0002, 1'b0, 1'b0, 4'd0, 11,  5, 0};
        vecs[10] = '{2'd2, 16'h0058, 1, 16'h0000, 1'b0, 1'b1, 4'd4,  3,  1, 0};
        vecs[11] = '{2'd0, 16'h0058, 2, 16'h3000, 1'b0, 1'b0, 4'd0,  4,  1, 0};
        vecs[12] = '{2'd3, 16'h0060, 1, 16'h0000, 1'b0, 1'b1, 4'd5, 36, 17, 8};
        vecs[13] = '{2'd2, 16'h0018, 1, 16'h000F, 1'b0, 1'b0, 4'd0, 15,  7, 0};
        vecs[14] = '{2'd3, 16'h0018, 1, 16'h0007, 1'b0, 1'b0, 4'd0, 15,  7, 0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset error", 32'(error), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset error_code", 32'(error_code), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            tag = $sformatf("v%0d", i);
            if (vecs[i].exp_err) exp_code_track = vecs[i].exp_code;
            base_req = req_count;
            base_car = car62_count;
            applyStimulus(vecs[i].mode, vecs[i].root, vecs[i].lat);
            waitDone(tag);
            checkOutput({tag, " result"}, 32'(result), 32'(vecs[i].exp_result));
            checkOutput({tag, " overflow"}, 32'(overflow), 32'(vecs[i].exp_ovf));
            checkOutput({tag, " error"}, 32'(error), 32'(vecs[i].exp_err));
            checkOutput({tag, " done"}, 32'(done), 32'(!vecs[i].exp_err));
            checkOutput({tag, " busy"}, 32'(busy), 32'd0);
            checkOutput({tag, " error_code"}, 32'(error_code), 32'(exp_code_track));
            checkOutput({tag, " cycles"}, 32'(cycle_cnt), 32'(vecs[i].exp_cycles));
            checkOutput({tag, " mem_req count"}, 32'(req_count - base_req), 32'(vecs[i].exp_reqs));
            checkOutput({tag, " car reads 0x62"}, 32'(car62_count - base_car), 32'(vecs[i].exp_car62));
        end

        // A second start while busy must not disturb the running SUM.
        base_req = req_count;
        applyStimulus(2'd2, 16'h0018, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
            cycle_cnt++;
        end
        checkOutput("busy before restart", 32'(busy), 32'd1);
        start     = 1'b1;
        mode      = 2'd3;
        root_addr = 16'h0030;
        @(posedge clk);
        #1;
        cycle_cnt++;
        start = 1'b0;
        waitDone("busy-start");
        checkOutput("busy-start result", 32'(result), 32'h000F);
        checkOutput("busy-start cycles", 32'(cycle_cnt), 32'd22);
        checkOutput("busy-start mem_req count", 32'(req_count - base_req), 32'd7);

        // Reset while waiting for a car; its response then arrives in Idle.
        base_req = req_count;
        applyStimulus(2'd2, 16'h0018, 6);
        for (int k = 0; k < 60 && (req_count - base_req) < 2; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reached car wait", 32'(req_count - base_req), 32'd2);
        checkOutput("busy in car wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_code_track = 4'd0;
        checkOutput("mid-reset busy", 32'(busy), 32'd0);
        checkOutput("mid-reset mem_req", 32'(mem_req), 32'd0);
        bad_cycles = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (busy || done || error || mem_req) bad_cycles++;
        end
        checkOutput("stale rvalid idle cycles", 32'(bad_cycles), 32'd0);
        checkOutput("stale rvalid no new req", 32'(req_count - base_req), 32'd2);
        checkOutput("post-reset result", 32'(result), 32'd0);
        checkOutput("post-reset overflow", 32'(overflow), 32'd0);
        checkOutput("post-reset error_code", 32'(error_code), 32'(exp_code_track));

        base_req = req_count;
        applyStimulus(2'd3, 16'h0018, 1);
        waitDone("after-reset");
        checkOutput("after-reset result", 32'(result), 32'h0007);
        checkOutput("after-reset done", 32'(done), 32'd1);
        checkOutput("after-reset cycles", 32'(cycle_cnt), 32'd15);
        checkOutput("after-reset mem_req count", 32'(req_count - base_req), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
